// File: rtl/fetch_redirect_ctrl.sv
// Frontend redirect sequencer: arbitrates backend/predecode redirects, pulses flush, then presents the refill address.
// Latency: request accepted in cycle N -> flush in N+1 -> refill_valid from N+2 until fetch_ready.
// Backpressure: refill is held stable while fetch_ready is low; pd requests are dropped while busy; a backend redirect always wins.
module fetch_redirect_ctrl #(
   parameter int FSQ_WIDTH  = 4,
   parameter int PRED_WIDTH = 3,
   parameter int VADDR_SIZE = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  be_redir_en,
   input  logic [FSQ_WIDTH-1:0]  be_redir_fsq,
   input  logic [VADDR_SIZE-1:0] be_redir_pc,
   input  logic                  pd_redir_en,
   input  logic [FSQ_WIDTH-1:0]  pd_redir_fsq,
   input  logic [PRED_WIDTH-1:0] pd_redir_offset,
   input  logic [VADDR_SIZE-1:0] pd_redir_pc,
   input  logic                  ibuf_full,
   input  logic                  fetch_ready,
   output logic                  flush,
   output logic                  refill_valid,
   output logic [VADDR_SIZE-1:0] refill_pc,
   output logic [FSQ_WIDTH-1:0]  refill_fsq,
   output logic [PRED_WIDTH-1:0] refill_offset,
   output logic                  refill_src,
   output logic                  pd_stall,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  be_cnt,
   output logic [CNT_WIDTH-1:0]  pd_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      REFILL = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t state, state_nxt;
   logic   be_take;
   logic   pd_take;

   // Backend is accepted in any state; predecode only when idle and not beaten by backend.
   assign be_take = be_redir_en;
   assign pd_take = pd_redir_en & ~be_redir_en & (state == IDLE);

   // Flushed entries must drain, so the stall only applies while idle.
   assign pd_stall = ibuf_full & (state == IDLE);
   assign busy     = (state != IDLE);

   // Next-state: a backend redirect restarts the flush from any state, including the refill handshake cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (be_take || pd_take) state_nxt = FLUSH;
         FLUSH:   state_nxt = be_take ? FLUSH : REFILL;
         REFILL: begin
            if (be_take)          state_nxt = FLUSH;
            else if (fetch_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with registered flush/refill_valid decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         flush        <= 1'b0;
         refill_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         flush        <= (state_nxt == FLUSH);
         refill_valid <= (state_nxt == REFILL);
      end
   end

   // Capture the winning redirect's fields; they stay put until the next accepted redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         refill_pc     <= '0;
         refill_fsq    <= '0;
         refill_offset <= '0;
         refill_src    <= 1'b0;
      end else if (be_take) begin
         refill_pc     <= be_redir_pc;
         refill_fsq    <= be_redir_fsq;
         refill_offset <= '0;
         refill_src    <= 1'b0;
      end else if (pd_take) begin
         refill_pc     <= pd_redir_pc;
         refill_fsq    <= pd_redir_fsq;
         refill_offset <= pd_redir_offset;
         refill_src    <= 1'b1;
      end
   end

   // Saturating per-source counters of accepted redirects.
   always_ff @(posedge clk) begin
      if (rst) begin
         be_cnt <= '0;
         pd_cnt <= '0;
      end else begin
         if (be_take && be_cnt != CNT_MAX) be_cnt <= be_cnt + CNT_ONE;
         if (pd_take && pd_cnt != CNT_MAX) pd_cnt <= pd_cnt + CNT_ONE;
      end
   end

endmodule
